// File: rtl/seg_scan.sv
// Four-digit multiplexed hex display scanner with frame-synchronous display
// updates, leading-zero suppression and per-digit forced blanking.
module seg_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lz_en,
    input  logic [3:0]  blank,
    output logic [3:0]  num,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    sel;
    logic          wrap;
    logic [15:0]   pend;
    logic          pend_vld;
    logic [15:0]   disp;

    logic [3:0]    nz;
    logic [3:0]    supp;
    logic          off;

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (sel == 2'd3);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt         <= '0;
            sel         <= 2'd0;
            pend        <= '0;
            pend_vld    <= 1'b0;
            disp        <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + CW'(1);
            frame_start <= wrap;
            if (tick)
                sel <= sel + 2'd1;

            // disp samples the old pend, so a load landing on the wrap edge
            // is kept pending for the following frame.
            if (wrap && pend_vld)
                disp <= pend;

            if (load) begin
                pend     <= value;
                pend_vld <= 1'b1;
            end else if (wrap && pend_vld) begin
                pend_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        nz[0] = |disp[3:0];
        nz[1] = |disp[7:4];
        nz[2] = |disp[11:8];
        nz[3] = |disp[15:12];

        // Digit i is a leading zero when it and every more significant
        // nibble are zero; the rightmost digit is always shown.
        supp    = 4'b0000;
        supp[3] = lz_en & ~nz[3];
        supp[2] = lz_en & ~nz[3] & ~nz[2];
        supp[1] = lz_en & ~nz[3] & ~nz[2] & ~nz[1];

        case (sel)
            2'd0:    num = disp[3:0];
            2'd1:    num = disp[7:4];
            2'd2:    num = disp[11:8];
            default: num = disp[15:12];
        endcase

        off = supp[sel] | blank[sel];
        an  = off ? 4'b1111 : ~(4'b0001 << sel);
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed self-checking bench for seg_scan with SCAN_DIV=4 (16-cycle frames).
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] value;
    logic        load;
    logic        lz_en;
    logic [3:0]  blank;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    seg_scan #(.SCAN_DIV(4)) dut (
        .clk         (clk),
        .clr         (clr),
        .value       (value),
        .load        (load),
        .lz_en       (lz_en),
        .blank       (blank),
        .num         (num),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_frame();
        int n = 0;
        while (frame_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", frame_start, n);
        end
    endtask

    task automatic test_reset();
        clr   = 1'b1;
        load  = 1'b1;
        value = 16'hFFFF;
        lz_en = 1'b0;
        blank = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        clr  = 1'b0;
        load = 1'b0;
        total++;
        if (an !== 4'b1110 || num !== 4'h0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: an=%b num=%h fs=%b, required an=1110 num=0 fs=0", an, num, frame_start);
        end
        total++;
        if (dut.disp !== 16'h0000 || dut.pend !== 16'h0000 || dut.pend_vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: disp=%h pend=%h vld=%b, required 0000 0000 0", dut.disp, dut.pend, dut.pend_vld);
        end
    endtask

    task automatic test_load_frame();
        logic [15:0] exp_an = 16'h7BDE;
        logic [15:0] exp_num = 16'h1234;
        value = 16'h1234;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int n = 0; n < 40 && frame_start !== 1'b1; n++) begin
            total++;
            if (dut.disp !== 16'h0000) begin
                bad++;
                $display("FAIL disp_hold: disp=%h before wrap, required 0000", dut.disp);
            end
            @(negedge clk);
        end
        wait_frame();
        for (int k = 0; k < 16; k++) begin
            int d = k / 4;
            total++;
            if (an !== exp_an[4*d +: 4] || num !== exp_num[4*d +: 4]) begin
                bad++;
                $display("FAIL load_scan k=%0d: an=%b num=%h, required an=%b num=%h",
                         k, an, num, exp_an[4*d +: 4], exp_num[4*d +: 4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [5] = '{16'h00A0, 16'h0000, 16'h1000, 16'h0305, 16'h00A0};
        logic        lzs  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] ans  [5] = '{16'hFFDE, 16'hFFFE, 16'h7BDE, 16'hFBDE, 16'h7BDE};
        for (int v = 0; v < 5; v++) begin
            wait_frame();
            lz_en = lzs[v];
            value = vals[v];
            load  = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_frame();
            for (int k = 0; k < 16; k++) begin
                int d = k / 4;
                total++;
                if (an !== ans[v][4*d +: 4] || num !== vals[v][4*d +: 4]) begin
                    bad++;
                    $display("FAIL lz v=%0d k=%0d: an=%b num=%h, required an=%b num=%h",
                             v, k, an, num, ans[v][4*d +: 4], vals[v][4*d +: 4]);
                end
                @(negedge clk);
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        wait_frame();
        value = 16'h1111;
        load  = 1'b1;
        @(negedge clk);
        value = 16'h5555;
        @(negedge clk);
        load = 1'b0;
        total++;
        if (dut.pend !== 16'h5555 || dut.pend_vld !== 1'b1) begin
            bad++;
            $display("FAIL pend_last: pend=%h vld=%b, required 5555 1", dut.pend, dut.pend_vld);
        end
        repeat (13) @(negedge clk);
        total++;
        if (frame_start !== 1'b0 || dut.disp !== 16'h00A0) begin
            bad++;
            $display("FAIL pre_wrap: fs=%b disp=%h, required 0 00A0", frame_start, dut.disp);
        end
        value = 16'hBEEF;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        total++;
        if (frame_start !== 1'b1 || dut.disp !== 16'h5555 || dut.pend !== 16'hBEEF || dut.pend_vld !== 1'b1) begin
            bad++;
            $display("FAIL wrap_load: fs=%b disp=%h pend=%h vld=%b, required 1 5555 BEEF 1",
                     frame_start, dut.disp, dut.pend, dut.pend_vld);
        end
        total++;
        if (an !== 4'b1110 || num !== 4'h5) begin
            bad++;
            $display("FAIL wrap_digit: an=%b num=%h, required 1110 5", an, num);
        end
        repeat (16) @(negedge clk);
        total++;
        if (frame_start !== 1'b1 || dut.disp !== 16'hBEEF || dut.pend_vld !== 1'b0) begin
            bad++;
            $display("FAIL next_wrap: fs=%b disp=%h vld=%b, required 1 BEEF 0", frame_start, dut.disp, dut.pend_vld);
        end
        total++;
        if (an !== 4'b1110 || num !== 4'hF) begin
            bad++;
            $display("FAIL next_digit: an=%b num=%h, required 1110 F", an, num);
        end
    endtask

    task automatic test_blank();
        logic [15:0] exp_an = 16'h7FDE;
        logic [15:0] exp_num = 16'hBEEF;
        wait_frame();
        blank = 4'b0100;
        #1;
        for (int k = 0; k < 16; k++) begin
            int d = k / 4;
            total++;
            if (an !== exp_an[4*d +: 4] || num !== exp_num[4*d +: 4]) begin
                bad++;
                $display("FAIL blank k=%0d: an=%b num=%h, required an=%b num=%h",
                         k, an, num, exp_an[4*d +: 4], exp_num[4*d +: 4]);
            end
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        total++;
        if (an !== 4'b1111 || num !== 4'hE) begin
            bad++;
            $display("FAIL blank_mid: an=%b num=%h, required 1111 E", an, num);
        end
        blank = 4'b0000;
        #1;
        total++;
        if (an !== 4'b1011) begin
            bad++;
            $display("FAIL unblank_comb: an=%b, required 1011", an);
        end
    endtask

    task automatic test_clr_mid();
        wait_frame();
        repeat (9) @(negedge clk);
        total++;
        if (dut.sel !== 2'd2 || dut.cnt !== 2'd1) begin
            bad++;
            $display("FAIL clr_setup: sel=%0d cnt=%0d, required 2 1", dut.sel, dut.cnt);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (dut.sel !== 2'd0 || dut.cnt !== 2'd0 || an !== 4'b1110 || num !== 4'h0) begin
            bad++;
            $display("FAIL clr_mid: sel=%0d cnt=%0d an=%b num=%h, required 0 0 1110 0", dut.sel, dut.cnt, an, num);
        end
        total++;
        if (dut.disp !== 16'h0000 || dut.pend_vld !== 1'b0 || frame_start !== 1'b0) begin
            bad++;
            $display("FAIL clr_state: disp=%h vld=%b fs=%b, required 0000 0 0", dut.disp, dut.pend_vld, frame_start);
        end
    endtask

    // Expects to start on the first cycle after reset is released.
    task automatic test_frames();
        int pulses = 0;
        logic [1:0] prev_sel = 2'd0;
        for (int t = 0; t < 56; t++) begin
            if (frame_start === 1'b1) begin
                pulses++;
                total++;
                if (t != 16 * pulses || dut.sel !== 2'd0 || prev_sel !== 2'd3) begin
                    bad++;
                    $display("FAIL frame_pulse: pulse %0d at t=%0d sel=%0d prev=%0d, required t=%0d sel=0 prev=3",
                             pulses, t, dut.sel, prev_sel, 16 * pulses);
                end
            end
            prev_sel = dut.sel;
            @(negedge clk);
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL frame_count: pulses=%0d, required 3", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_load_frame();
        test_lz();
        test_back_to_back();
        test_blank();
        test_clr_mid();
        test_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
